jseq_divider: RTL and testbench
===============================

JSEQ_DIVIDER -- requirements
Module: jseq_divider

Interface
REQ-001 Parameters: none; widths are fixed by package constants (dividend 8 bits, divisor 4 bits).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend, captured on the accepting edge.
REQ-006 divisor  input  4  unsigned divisor, captured on the accepting edge.
REQ-007 busy  output  1  high in CALC and DONE.
REQ-008 done  output  1  one-cycle pulse; results valid while high.
REQ-009 quotient  output  8  unsigned quotient.
REQ-010 remainder  output  4  unsigned remainder.
REQ-011 div_by_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 IDLE with start=1 at edge E0: capture operands, clear working quotient and partial remainder, load iteration counter with 7, go to CALC.
REQ-014 CALC: one restoring step per edge, E1..E8, processing dividend bits MSB first.
- Step: p = {r[3:0], next dividend bit} (5 bits).
- If p >= divisor: r = p - divisor, quotient bit = 1.
- Otherwise: r = p[3:0], quotient bit = 0.
REQ-015 At E8 the block SHALL load quotient, remainder and div_by_zero from the working registers and go to DONE, so done is high in the cycle between E8 and E9.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE; start is ignored in DONE.
REQ-017 start is ignored in CALC and DONE; captured operands SHALL NOT change mid-operation.
REQ-018 quotient, remainder and div_by_zero SHALL hold their values from the last done until the next done; they do not show intermediate values.
REQ-019 Divisor 0 without the early-exit feature: the step rule gives quotient=8'hFF and remainder=dividend[3:0], using the normal 8-step latency.
REQ-020 With start held high continuously, a new operation SHALL be accepted on the first IDLE edge after DONE (every 10 cycles).

Reset
REQ-021 On a clk edge with rst_n=0, from any state including mid-CALC:
- state = IDLE, counter = 0;
- busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0;
- any in-flight operation is discarded.
REQ-022 start SHALL be ignored on any edge where rst_n=0.

Configuration
REQ-023 Macro JDIV_ZERO_DETECT_EN selects divide-by-zero early exit.
REQ-024 With JDIV_ZERO_DETECT_EN defined: if the captured divisor is 0 at E0, the block SHALL skip CALC and go to DONE at E1.
- Results loaded at E1: quotient = 8'hFF, remainder = dividend[3:0], div_by_zero = 1.
- Any nonzero divisor gives div_by_zero = 0.
REQ-025 Without JDIV_ZERO_DETECT_EN: div_by_zero SHALL be tied 0 and divisor 0 follows REQ-019.

Structure
REQ-026 Package jdiv_pkg SHALL hold:
- DVD_W = 8, DVS_W = 4, ITER = 8;
- the FSM state enum type.
REQ-027 Sub-module jdiv_step SHALL be the combinational single-iteration cell.
- Inputs: r[3:0], in_bit, divisor[3:0].
- Outputs: r_next[3:0], q_bit.
- It is instantiated once and reused each cycle.

Verification
REQ-028 200/7: start at E0 -> done high after E8, quotient=28, remainder=4, div_by_zero=0.
REQ-029 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 0/15 -> quotient=0, remainder=0.
REQ-030 8'hA7/0: macro defined -> done after E1, quotient=8'hFF, remainder=4'h7, div_by_zero=1; macro undefined -> done after E8, same quotient/remainder, div_by_zero=0.
REQ-031 start with 100/3 at E0, then start with 9/2 at E3 -> second request ignored, result quotient=33, remainder=1, busy high E0..E9.
REQ-032 rst_n low at E4 of 200/7 -> after that edge state IDLE, all outputs 0, and no done pulse for the aborted operation.
REQ-033 start held high with constant operands -> done pulses exactly every 10 cycles with identical results; exhaustive 8x4-bit sweep matches the reference model.

Source files
------------

// File: rtl/jdiv_pkg.sv
// Shared widths and FSM state type for the sequential restoring divider.
package jdiv_pkg;
  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/jdiv_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module jdiv_step
  import jdiv_pkg::*;
(
  input  logic [DVS_W-1:0] r,
  input  logic             in_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] r_next,
  output logic             q_bit
);
  logic [DVS_W:0] p;

  assign p      = {r, in_bit};
  assign q_bit  = (p >= {1'b0, divisor});
  // r < divisor on entry, so p - divisor < divisor and fits in DVS_W bits
  assign r_next = q_bit ? (p[DVS_W-1:0] - divisor) : p[DVS_W-1:0];
endmodule

// File: rtl/jseq_divider.sv
// 8/4-bit sequential restoring divider, one quotient bit per cycle.
// Define JDIV_ZERO_DETECT_EN to finish divide-by-zero after a single cycle.
module jseq_divider
  import jdiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DVD_W-1:0]   dvd_q, dvd_d;
  logic [DVS_W-1:0]   dvs_q, dvs_d;
  logic [DVS_W-1:0]   r_q, r_d;
  logic [DVD_W-1:0]   wq_q, wq_d;
  logic [DVD_W-1:0]   quo_q, quo_d;
  logic [DVS_W-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [DVS_W-1:0]   step_r;
  logic               step_q;

  jdiv_step u_step (
    .r       (r_q),
    .in_bit  (dvd_q[cnt_q]),
    .divisor (dvs_q),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    r_d     = r_q;
    wq_d    = wq_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          r_d     = '0;
          wq_d    = '0;
          cnt_d   = CNT_W'(ITER - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        r_d   = step_r;
        wq_d  = {wq_q[DVD_W-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quo_d   = {wq_q[DVD_W-2:0], step_q};
          rem_d   = step_r;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
`ifdef JDIV_ZERO_DETECT_EN
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q[DVS_W-1:0];
          dbz_d   = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      r_q     <= '0;
      wq_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      r_q     <= r_d;
      wq_q    <= wq_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  // stays 0 without the zero-detect build since dbz_d is never set
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_jseq_divider.sv
// Directed self-checking bench for jseq_divider (honours JDIV_ZERO_DETECT_EN).
module tb_jseq_divider;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int total = 0;
  int bad   = 0;

`ifdef JDIV_ZERO_DETECT_EN
  localparam int ZLAT = 1;
  localparam bit ZFLG = 1'b1;
`else
  localparam int ZLAT = 8;
  localparam bit ZFLG = 1'b0;
`endif

  jseq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request at E0 and wait (bounded) for done; returns to IDLE afterwards.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] q,
                        output logic [3:0] r, output logic z);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick(); tick();
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    start = 1'b0; rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    run_op(8'd200, 4'd7, lat, q, r, z);
    total++;
    if (lat !== 8 || q !== 8'd28 || r !== 4'd4 || z !== 1'b0) begin
      bad++;
      $display("FAIL basic_200_7: got lat=%0d q=%0d r=%0d z=%b want lat=8 q=28 r=4 z=0", lat, q, r, z);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", done, busy);
    end
    dividend = 8'd1; divisor = 4'd1;
    tick(); tick(); tick();
    total++;
    if (quotient !== 8'd28 || remainder !== 4'd4) begin
      bad++;
      $display("FAIL result_hold: got q=%0d r=%0d want q=28 r=4", quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [3] = '{8'd255, 8'd5, 8'd0};
    logic [3:0] vb [3] = '{4'd1, 4'd9, 4'd15};
    logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd0};
    logic [3:0] er [3] = '{4'd0, 4'd5, 4'd0};
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, q, r, z);
      total++;
      if (lat !== 8 || q !== eq[i] || r !== er[i] || z !== 1'b0) begin
        bad++;
        $display("FAIL vector_%0d_%0d: got lat=%0d q=%0d r=%0d z=%b want lat=8 q=%0d r=%0d z=0",
                 va[i], vb[i], lat, q, r, z, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    run_op(8'hA7, 4'd0, lat, q, r, z);
    total++;
    if (lat !== ZLAT || q !== 8'hFF || r !== 4'h7 || z !== ZFLG) begin
      bad++;
      $display("FAIL div_zero: got lat=%0d q=%h r=%h z=%b want lat=%0d q=ff r=7 z=%b",
               lat, q, r, z, ZLAT, ZFLG);
    end
    run_op(8'd9, 4'd3, lat, q, r, z);
    total++;
    if (q !== 8'd3 || r !== 4'd0 || z !== 1'b0) begin
      bad++;
      $display("FAIL dbz_clears: got q=%0d r=%0d z=%b want q=3 r=0 z=0", q, r, z);
    end
  endtask

  task automatic test_ignore_start();
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) begin
        start = 1'b1; dividend = 8'd9; divisor = 4'd2;
      end else begin
        start = 1'b0;
      end
      tick();
      total++;
      if (busy !== (k <= 8)) begin
        bad++;
        $display("FAIL busy_E%0d: got %b want %b", k, busy, (k <= 8));
      end
      if (k == 8) begin
        total++;
        if (done !== 1'b1 || quotient !== 8'd33 || remainder !== 4'd1) begin
          bad++;
          $display("FAIL ignore_start: got done=%b q=%0d r=%0d want done=1 q=33 r=1",
                   done, quotient, remainder);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    int ndone = 0;
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      bad++;
      $display("FAIL abort_reset: got busy=%b done=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int hits [$];
    logic [7:0] qs [$];
    logic [3:0] rs [$];
    start = 1'b1; dividend = 8'd60; divisor = 4'd7;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (done) begin
        hits.push_back(i); qs.push_back(quotient); rs.push_back(remainder);
      end
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (hits.size() !== 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d done pulses want 3", hits.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        total++;
        if (hits[j] !== 8 + 10*j || qs[j] !== 8'd8 || rs[j] !== 4'd4) begin
          bad++;
          $display("FAIL b2b_%0d: got cycle=%0d q=%0d r=%0d want cycle=%0d q=8 r=4",
                   j, hits[j], qs[j], rs[j], 8 + 10*j);
        end
      end
    end
  endtask

  task automatic test_sweep();
    int lat; logic [7:0] q; logic [3:0] r; logic z;
    logic [7:0] eq; logic [3:0] er; logic ez;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          eq = 8'hFF; er = 4'(a % 16); ez = ZFLG;
        end else begin
          eq = 8'(a / b); er = 4'(a % b); ez = 1'b0;
        end
        run_op(8'(a), 4'(b), lat, q, r, z);
        total++;
        if (q !== eq || r !== er || z !== ez) begin
          bad++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                   a, b, q, r, z, eq, er, ez);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
